// File: rtl/midi_key_transmitter_if.sv
// Key/control inputs and MIDI serial outputs of the key-to-MIDI transmitter.
// The master side drives keys and controls; the slave side is the transmitter.
interface midi_key_transmitter_if #(
    parameter int N_KEYS = 10
);
    logic [N_KEYS-1:0] key;
    logic              ena;
    logic [6:0]        prog;
    logic [4:0]        pitchshift;
    logic              tx;
    logic              busy;

    modport master (output key, ena, prog, pitchshift, input tx, busy);
    modport slave  (input key, ena, prog, pitchshift, output tx, busy);
endinterface

// File: rtl/midi_key_transmitter.sv
// Scans key lines and sends Note On/Off and Program Change messages on one MIDI
// channel, serialised 8N1 on tx with optional running status and clamped pitch shift.
module midi_key_transmitter #(
    parameter int N_KEYS         = 10,
    parameter int CHANNEL        = 0,
    parameter int BASE_NOTE      = 60,
    parameter int VELOCITY       = 100,
    parameter int CLKS_PER_BIT   = 3200,
    parameter int RUNNING_STATUS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    midi_key_transmitter_if.slave  bus
);
    localparam int IDX_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0] CH_NIB  = 8'(CHANNEL & 15);
    localparam logic [7:0] ST_PC   = 8'hC0 | CH_NIB;
    localparam logic [7:0] ST_ON   = 8'h90 | CH_NIB;
    localparam logic [7:0] ST_OFF  = (RUNNING_STATUS != 0) ? ST_ON : (8'h80 | CH_NIB);
    localparam logic [7:0] VEL_ON  = 8'(VELOCITY);
    localparam logic [7:0] VEL_OFF = (RUNNING_STATUS != 0) ? 8'h00 : 8'h40;
    localparam logic signed [8:0] BASE_S = 9'(BASE_NOTE);

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_STATUS, S_DATA1, S_DATA2} state_t;

    function automatic logic [6:0] clamp_note(input logic signed [8:0] v);
        if (v < 9'sd0)
            return 7'd0;
        else if (v > 9'sd127)
            return 7'd127;
        else
            return v[6:0];
    endfunction

    state_t            state, state_nx;
    logic [N_KEYS-1:0] sounding;
    logic [6:0]        note_q [N_KEYS];
    logic [7:0]        last_status;
    logic              ls_valid;
    logic [6:0]        last_prog;
    logic              prog_init;
    logic              busy_q;
    logic [7:0]        msg_d1, msg_d2;
    logic              msg_two;

    logic [N_KEYS-1:0] want, need;
    logic              prog_pending, work;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_found;
    logic signed [8:0] idx_s, shift_s, note_sum;
    logic [6:0]        note_on;
    logic [7:0]        sel_status, sel_d1, sel_d2;
    logic              sel_two, sel_skip;

    logic              u_start, u_done, u_active, u_tx;
    logic [7:0]        u_din;
    logic [9:0]        u_sh;
    logic [3:0]        u_bit;
    logic [CNT_W-1:0]  u_cnt;

    assign want         = bus.key & {N_KEYS{bus.ena}};
    assign need         = want ^ sounding;
    assign prog_pending = prog_init | (bus.prog != last_prog);
    assign work         = prog_pending | (|need);

    // Lowest-index key whose wanted level differs from what is sounding.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int k = N_KEYS - 1; k >= 0; k--) begin
            if (need[k]) begin
                sel_idx   = IDX_W'(k);
                sel_found = 1'b1;
            end
        end
    end

    assign idx_s    = 9'(sel_idx);
    assign shift_s  = {{4{bus.pitchshift[4]}}, bus.pitchshift};
    assign note_sum = BASE_S + idx_s + shift_s;
    assign note_on  = clamp_note(note_sum);

    always_comb begin
        sel_status = ST_PC;
        sel_d1     = {1'b0, bus.prog};
        sel_d2     = 8'h00;
        sel_two    = 1'b0;
        if (!prog_pending) begin
            sel_two = 1'b1;
            if (want[sel_idx]) begin
                sel_status = ST_ON;
                sel_d1     = {1'b0, note_on};
                sel_d2     = VEL_ON;
            end else begin
                // Note Off always names the note latched at Note On time.
                sel_status = ST_OFF;
                sel_d1     = {1'b0, note_q[sel_idx]};
                sel_d2     = VEL_OFF;
            end
        end
        sel_skip = (RUNNING_STATUS != 0) && ls_valid && (sel_status == last_status);
    end

    // Each byte is launched on the cycle the previous one finishes, keeping frames contiguous.
    always_comb begin
        state_nx = state;
        u_start  = 1'b0;
        u_din    = sel_status;
        case (state)
            S_IDLE: if (work) state_nx = S_SELECT;
            S_SELECT: begin
                if (work) begin
                    u_start = 1'b1;
                    if (sel_skip) begin
                        u_din    = sel_d1;
                        state_nx = S_DATA1;
                    end else begin
                        state_nx = S_STATUS;
                    end
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_STATUS: begin
                if (u_done) begin
                    u_start  = 1'b1;
                    u_din    = msg_d1;
                    state_nx = S_DATA1;
                end
            end
            S_DATA1: begin
                if (u_done) begin
                    if (msg_two) begin
                        u_start  = 1'b1;
                        u_din    = msg_d2;
                        state_nx = S_DATA2;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            S_DATA2: if (u_done) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            sounding    <= '0;
            last_status <= 8'h00;
            ls_valid    <= 1'b0;
            last_prog   <= 7'd0;
            prog_init   <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state  <= state_nx;
            busy_q <= (state != S_IDLE) | work;
            if (state == S_SELECT && work) begin
                last_status <= sel_status;
                ls_valid    <= 1'b1;
                if (prog_pending) begin
                    last_prog <= bus.prog;
                    prog_init <= 1'b0;
                end else begin
                    sounding[sel_idx] <= want[sel_idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_SELECT && !prog_pending && sel_found && want[sel_idx])
            note_q[sel_idx] <= note_on;
        if (state == S_SELECT) begin
            msg_d1  <= sel_d1;
            msg_d2  <= sel_d2;
            msg_two <= sel_two;
        end
    end

    // UART: frame is {stop, data[7:0], start}, shifted out LSB first.
    assign u_done = u_active && (u_cnt == CNT_LAST) && (u_bit == 4'd9);

    always_ff @(posedge clk) begin
        if (rst) begin
            u_active <= 1'b0;
            u_tx     <= 1'b1;
        end else if (u_start) begin
            u_active <= 1'b1;
            u_tx     <= 1'b0;
        end else if (u_active && u_cnt == CNT_LAST) begin
            if (u_bit == 4'd9)
                u_active <= 1'b0;
            else
                u_tx <= u_sh[1];
        end
    end

    always_ff @(posedge clk) begin
        if (u_start) begin
            u_sh  <= {1'b1, u_din, 1'b0};
            u_cnt <= '0;
            u_bit <= 4'd0;
        end else if (u_active) begin
            if (u_cnt == CNT_LAST) begin
                u_cnt <= '0;
                u_bit <= u_bit + 4'd1;
                u_sh  <= {1'b1, u_sh[9:1]};
            end else begin
                u_cnt <= u_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.tx   = u_tx;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_midi_key_transmitter.sv
// Bench for midi_key_transmitter: four parameter variants, a UART receiver per
// instance, directed message checks and a randomized run against a message-level model.
module tb_midi_key_transmitter;
    localparam int CPB = 8;
    localparam int NK  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;

    midi_key_transmitter_if #(.N_KEYS(NK)) ifa ();
    midi_key_transmitter_if #(.N_KEYS(NK)) ifb ();
    midi_key_transmitter_if #(.N_KEYS(NK)) ifc ();
    midi_key_transmitter_if #(.N_KEYS(NK)) ifd ();

    midi_key_transmitter #(.N_KEYS(NK), .CHANNEL(0), .BASE_NOTE(60), .VELOCITY(100),
        .CLKS_PER_BIT(CPB), .RUNNING_STATUS(1)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    midi_key_transmitter #(.N_KEYS(NK), .CHANNEL(0), .BASE_NOTE(60), .VELOCITY(100),
        .CLKS_PER_BIT(CPB), .RUNNING_STATUS(0)) u_b (.clk(clk), .rst(rst), .bus(ifb));
    midi_key_transmitter #(.N_KEYS(NK), .CHANNEL(0), .BASE_NOTE(120), .VELOCITY(100),
        .CLKS_PER_BIT(CPB), .RUNNING_STATUS(1)) u_c (.clk(clk), .rst(rst), .bus(ifc));
    midi_key_transmitter #(.N_KEYS(NK), .CHANNEL(3), .BASE_NOTE(0), .VELOCITY(100),
        .CLKS_PER_BIT(CPB), .RUNNING_STATUS(1)) u_d (.clk(clk), .rst(rst), .bus(ifd));

    logic [3:0] txv, busyv;
    assign txv   = {ifd.tx, ifc.tx, ifb.tx, ifa.tx};
    assign busyv = {ifd.busy, ifc.busy, ifb.busy, ifa.busy};

    // Received entries are {frame_ok, byte}; frames overlapped by reset are dropped.
    logic [8:0] rxq0[$], rxq1[$], rxq2[$], rxq3[$];
    longint     rxt0[$];
    logic [7:0] expq[$];

    task automatic rx_byte(input int d, output logic [7:0] b, output logic ok,
                           output logic ab, output longint t);
        ab = 1'b0;
        b  = 8'h00;
        @(negedge clk);
        while (txv[d] !== 1'b0) @(negedge clk);
        t = cyc;
        repeat (CPB / 2) begin @(negedge clk); if (rst) ab = 1'b1; end
        ok = (txv[d] === 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) begin @(negedge clk); if (rst) ab = 1'b1; end
            b[i] = txv[d];
        end
        repeat (CPB) begin @(negedge clk); if (rst) ab = 1'b1; end
        ok = ok & (txv[d] === 1'b1);
    endtask

    always begin : rx_a
        logic [7:0] b; logic ok, ab; longint t;
        rx_byte(0, b, ok, ab, t);
        if (!ab) begin rxq0.push_back({ok, b}); rxt0.push_back(t); end
    end
    always begin : rx_b
        logic [7:0] b; logic ok, ab; longint t;
        rx_byte(1, b, ok, ab, t);
        if (!ab) rxq1.push_back({ok, b});
    end
    always begin : rx_c
        logic [7:0] b; logic ok, ab; longint t;
        rx_byte(2, b, ok, ab, t);
        if (!ab) rxq2.push_back({ok, b});
    end
    always begin : rx_d
        logic [7:0] b; logic ok, ab; longint t;
        rx_byte(3, b, ok, ab, t);
        if (!ab) rxq3.push_back({ok, b});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_rx(input int d, output logic [8:0] v, output bit emp);
        emp = 1'b0;
        v   = '0;
        case (d)
            0: if (rxq0.size() == 0) emp = 1'b1; else v = rxq0.pop_front();
            1: if (rxq1.size() == 0) emp = 1'b1; else v = rxq1.pop_front();
            2: if (rxq2.size() == 0) emp = 1'b1; else v = rxq2.pop_front();
            default: if (rxq3.size() == 0) emp = 1'b1; else v = rxq3.pop_front();
        endcase
    endtask

    // Wait for the instance to go idle, then compare its received bytes with expq.
    task automatic check_msgs(input int d, input string tag);
        int lim;
        logic [8:0] v;
        bit emp;
        repeat (3) @(negedge clk);
        lim = 0;
        while (busyv[d] === 1'b1 && lim < 20000) begin @(negedge clk); lim++; end
        compared++;
        assert (busyv[d] === 1'b0) else begin
            mismatched++;
            $error("FAIL %s idle_timeout observed busy=%b expected 0", tag, busyv[d]);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < expq.size(); i++) begin
            pop_rx(d, v, emp);
            compared++;
            assert (!emp && v === {1'b1, expq[i]}) else begin
                mismatched++;
                $error("FAIL %s byte%0d observed=%h(empty=%0d) expected=%h",
                       tag, i, v, emp, {1'b1, expq[i]});
            end
        end
        pop_rx(d, v, emp);
        compared++;
        assert (emp) else begin
            mismatched++;
            $error("FAIL %s extra_byte observed=%h expected none", tag, v);
        end
        expq.delete();
    endtask

    task automatic drive(input int d, input logic [NK-1:0] k, input logic e,
                         input logic [6:0] p, input logic [4:0] s);
        @(posedge clk); #1;
        case (d)
            0: begin ifa.key = k; ifa.ena = e; ifa.prog = p; ifa.pitchshift = s; end
            1: begin ifb.key = k; ifb.ena = e; ifb.prog = p; ifb.pitchshift = s; end
            2: begin ifc.key = k; ifc.ena = e; ifc.prog = p; ifc.pitchshift = s; end
            default: begin ifd.key = k; ifd.ena = e; ifd.prog = p; ifd.pitchshift = s; end
        endcase
    endtask

    // Message-level model of instance A (channel 0, base 60, velocity 100, running status).
    bit m_sound[NK];
    int m_noteq[NK];
    int m_last_status;
    int m_last_prog;
    bit m_prog_init;

    task automatic m_status(input int s);
        if (m_last_status != s) expq.push_back(8'(s));
        m_last_status = s;
    endtask

    task automatic model_a(input logic [NK-1:0] k_in, input logic e_in, input int p_in, input int s_in);
        int k;
        int n;
        for (int guard = 0; guard < NK + 2; guard++) begin
            k = -1;
            if (m_prog_init || p_in != m_last_prog) begin
                m_status(8'hC0);
                expq.push_back(8'(p_in));
                m_last_prog = p_in;
                m_prog_init = 1'b0;
            end else begin
                for (int i = 0; i < NK; i++)
                    if (k < 0 && ((k_in[i] & e_in) != m_sound[i])) k = i;
                if (k < 0) break;
                m_status(8'h90);
                if (k_in[k] & e_in) begin
                    n = 60 + k + s_in;
                    if (n < 0) n = 0;
                    if (n > 127) n = 127;
                    m_noteq[k] = n;
                    expq.push_back(8'(n));
                    expq.push_back(8'd100);
                    m_sound[k] = 1'b1;
                end else begin
                    expq.push_back(8'(m_noteq[k]));
                    expq.push_back(8'h00);
                    m_sound[k] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NK-1:0] rk;
        logic          re;
        int            rp, rs, lim, txbad;
        longint        gap;

        ifa.key = '0; ifa.ena = 1'b0; ifa.prog = 7'd5; ifa.pitchshift = '0;
        ifb.key = '0; ifb.ena = 1'b0; ifb.prog = 7'd0; ifb.pitchshift = '0;
        ifc.key = '0; ifc.ena = 1'b0; ifc.prog = 7'd0; ifc.pitchshift = '0;
        ifd.key = '0; ifd.ena = 1'b0; ifd.prog = 7'd0; ifd.pitchshift = '0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_tx_a", 32'(txv[0]), 1);
        chk("rst_busy_a", 32'(busyv[0]), 0);
        chk("rst_tx_b", 32'(txv[1]), 1);
        chk("rst_busy_b", 32'(busyv[1]), 0);
        chk("rst_tx_d", 32'(txv[3]), 1);
        chk("rst_busy_d", 32'(busyv[3]), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Program Change after reset, bytes back to back
        expq = '{8'hC0, 8'h05};
        check_msgs(0, "t1_pc_a");
        gap = (rxt0.size() >= 2) ? rxt0[1] - rxt0[0] : -1;
        chk("t1_gap", 32'(gap), 10 * CPB);
        chk("t1_idle_tx", 32'(txv[0]), 1);
        chk("t1_idle_busy", 32'(busyv[0]), 0);
        expq = '{8'hC0, 8'h00};
        check_msgs(1, "t1_pc_b");
        expq = '{8'hC0, 8'h00};
        check_msgs(2, "t1_pc_c");
        expq = '{8'hC3, 8'h00};
        check_msgs(3, "t1_pc_d");

        // Note On / Off with running status
        rxt0.delete();
        drive(0, 10'b1, 1'b1, 7'd5, 5'd0);
        expq = '{8'h90, 8'h3C, 8'h64};
        check_msgs(0, "t2_on");
        gap = (rxt0.size() >= 3) ? rxt0[2] - rxt0[1] : -1;
        chk("t2_gap", 32'(gap), 10 * CPB);
        drive(0, 10'b0, 1'b1, 7'd5, 5'd0);
        expq = '{8'h3C, 8'h00};
        check_msgs(0, "t2_off");

        // Full status messages
        drive(1, 10'b100, 1'b1, 7'd0, 5'd0);
        expq = '{8'h90, 8'h3E, 8'h64};
        check_msgs(1, "t3_on");
        drive(1, 10'b0, 1'b1, 7'd0, 5'd0);
        expq = '{8'h80, 8'h3E, 8'h40};
        check_msgs(1, "t3_off");

        // Latched note survives a shift change
        drive(0, 10'b10, 1'b1, 7'd5, 5'd2);
        expq = '{8'h3F, 8'h64};
        check_msgs(0, "t4_on");
        drive(0, 10'b10, 1'b1, 7'd5, 5'b10000);
        check_msgs(0, "t4_shift_only");
        drive(0, 10'b0, 1'b1, 7'd5, 5'b10000);
        expq = '{8'h3F, 8'h00};
        check_msgs(0, "t4_off");

        // Clamping at both ends
        drive(2, 10'b10_0000_0000, 1'b1, 7'd0, 5'd15);
        expq = '{8'h90, 8'h7F, 8'h64};
        check_msgs(2, "t5_clamp_hi");
        drive(3, 10'b1, 1'b1, 7'd0, 5'b10000);
        expq = '{8'h93, 8'h00, 8'h64};
        check_msgs(3, "t5_clamp_lo");

        // Two keys held, then ena drops
        drive(0, 10'b00_1000_1000, 1'b1, 7'd5, 5'd0);
        expq = '{8'h3F, 8'h64, 8'h43, 8'h64};
        check_msgs(0, "t6_on_pair");
        drive(0, 10'b00_1000_1000, 1'b0, 7'd5, 5'd0);
        expq = '{8'h3F, 8'h00, 8'h43, 8'h00};
        check_msgs(0, "t6_ena_off");

        // Randomized steps on A against the model
        for (int i = 0; i < NK; i++) begin m_sound[i] = 1'b0; m_noteq[i] = 0; end
        m_last_status = 8'h90;
        m_last_prog   = 5;
        m_prog_init   = 1'b0;
        rp = 5;
        for (int it = 0; it < 12; it++) begin
            rk = NK'($urandom);
            re = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) rp = int'($urandom_range(0, 127));
            rs = int'($urandom_range(0, 31)) - 16;
            drive(0, rk, re, 7'(rp), 5'(rs));
            model_a(rk, re, rp, rs);
            check_msgs(0, "rnd");
        end

        // Reset in the middle of a byte
        drive(0, 10'b0, 1'b1, 7'(rp), 5'd0);
        model_a(10'b0, 1'b1, rp, 0);
        check_msgs(0, "t7_clear");
        drive(0, 10'b10_0000, 1'b1, 7'(rp), 5'd0);
        lim = 0;
        while (txv[0] !== 1'b0 && lim < 200) begin @(negedge clk); lim++; end
        chk("t7_start_seen", 32'(txv[0]), 0);
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t7_rst_tx", 32'(txv[0]), 1);
        txbad = 0;
        repeat (11 * CPB) begin
            @(negedge clk);
            if (txv[0] !== 1'b1) txbad++;
        end
        chk("t7_rst_hold_tx", 32'(txbad), 0);
        chk("t7_rst_busy", 32'(busyv[0]), 0);
        ifa.key = '0; ifa.ena = 1'b0; ifa.prog = 7'd9;
        @(posedge clk); #1;
        rst = 1'b0;
        expq = '{8'hC0, 8'h09};
        check_msgs(0, "t7_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
